turn_timer: RTL

Per-move countdown timer for the tic-tac-toe controller. Consumes the one-cycle `done` strobe of the upstream modulo tick counter as its `tick` input. Prescales that strobe down to whole seconds and counts down a two-digit BCD turn budget for the player to move. Tracks which player is on turn and pulses `timeout` when the budget runs out; the board FSM and seven-segment driver consume its outputs.

---
 rtl/turn_timer_if.sv | 23 ++
 rtl/turn_timer.sv | 100 ++++++++++
 2 files changed

// File: rtl/turn_timer_if.sv
// Control strobes and display/status outputs of the per-move turn timer.
interface turn_timer_if;
  logic       tick;
  logic       start;
  logic       pause;
  logic       move_done;
  logic       abort;
  logic [3:0] secs_tens;
  logic [3:0] secs_ones;
  logic       current_player;
  logic       running;
  logic       timeout;

  modport master (
    output tick, start, pause, move_done, abort,
    input  secs_tens, secs_ones, current_player, running, timeout
  );

  modport slave (
    input  tick, start, pause, move_done, abort,
    output secs_tens, secs_ones, current_player, running, timeout
  );
endinterface

// File: rtl/turn_timer.sv
// Per-move countdown: prescales tick strobes to seconds, counts a BCD budget
// down, tracks the player on turn and pulses timeout on expiry.
module turn_timer #(
  parameter int TURN_SECONDS  = 15,
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic         clk,
  input  logic         reset_n,
  turn_timer_if.slave  bus
);
  localparam int              PW         = $clog2(TICKS_PER_SEC);
  localparam logic [3:0]      TENS_INIT  = 4'(TURN_SECONDS / 10);
  localparam logic [3:0]      ONES_INIT  = 4'(TURN_SECONDS % 10);
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t        state, state_nxt;
  logic [3:0]    tens, ones;
  logic [PW-1:0] presc;
  logic          player;
  logic          timeout_q;

  // A counted tick in RUN: abort, move_done and pause all suppress it.
  logic sec_tick, last_sec;
  assign sec_tick = (state == RUN) && !bus.abort && !bus.move_done && !bus.pause
                    && bus.tick && (presc == PRESC_MAX);
  assign last_sec = (tens == 4'd0) && (ones == 4'd1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: default assignment first keeps this comb block latch-free.
  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (bus.start) state_nxt = RUN;
        RUN: begin
          if (bus.move_done)              state_nxt = RUN;
          else if (bus.pause)             state_nxt = PAUSED;
          else if (sec_tick && last_sec)  state_nxt = EXPIRED;
        end
        PAUSED:  if (!bus.pause) state_nxt = RUN;
        EXPIRED: if (bus.start) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tens      <= TENS_INIT;
      ones      <= ONES_INIT;
      presc     <= '0;
      player    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // Flags only the RUN->EXPIRED edge, so the pulse lasts one cycle.
      timeout_q <= (state == RUN) && (state_nxt == EXPIRED);
      if (bus.abort || (state == IDLE && bus.start)) begin
        tens   <= TENS_INIT;
        ones   <= ONES_INIT;
        presc  <= '0;
        player <= 1'b0;
      end else if ((state == RUN && bus.move_done) || (state == EXPIRED && bus.start)) begin
        tens   <= TENS_INIT;
        ones   <= ONES_INIT;
        presc  <= '0;
        player <= ~player;
      end else if (state == RUN && !bus.pause && bus.tick) begin
        if (presc == PRESC_MAX) begin
          presc <= '0;
          if (ones == 4'd0) begin
            ones <= 4'd9;
            tens <= tens - 4'd1;
          end else begin
            ones <= ones - 4'd1;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.secs_tens      = tens;
    bus.secs_ones      = ones;
    bus.current_player = player;
    bus.running        = (state == RUN);
    bus.timeout        = timeout_q;
  end
endmodule
